// File: rtl/riscv_tag_mode_pipe_pkg.sv
// Shared types for the tag-mode pipe: instruction classes (whose value is also the
// TPR field index), opcode constants and the write-coherency FSM states.
package riscv_tag_pkg;

    typedef enum logic [2:0] {
        CLS_JUMP       = 3'd0,
        CLS_JUMP_PC    = 3'd1,
        CLS_BRANCH     = 3'd2,
        CLS_LOADSTORE  = 3'd3,
        CLS_INTEGER    = 3'd4,
        CLS_SHIFT      = 3'd5,
        CLS_COMPARISON = 3'd6,
        CLS_LOGICAL    = 3'd7
    } tag_class_e;

    localparam int FLD_JUMP    = 0;
    localparam int FLD_JUMP_PC = 1;

    localparam int MODE_OLD = 0;

    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_OPIMM  = 7'h13;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_COMMIT = 2'd2
    } tag_state_e;

endpackage

// File: rtl/riscv_tag_mode_pipe_if.sv
// Instruction, TPR-write and result channels of the tag-mode pipe.
interface riscv_tag_mode_pipe_if #(
    parameter int MODE_W  = 2,
    parameter int NUM_CTX = 2,
    parameter int TPR_W   = 8 * MODE_W
);
    localparam int CTX_W = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1;

    logic              in_valid_i;
    logic              in_ready_o;
    logic [31:0]       instr_i;
    logic              pc_tag_i;
    logic [CTX_W-1:0]  ctx_i;
    logic              tpr_we_i;
    logic [CTX_W-1:0]  tpr_wctx_i;
    logic [TPR_W-1:0]  tpr_wdata_i;
    logic              tpr_wready_o;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [MODE_W-1:0] alu_mode_o;
    logic [MODE_W-1:0] jump_pc_mode_o;
    logic [2:0]        class_o;

    modport master (
        output in_valid_i, instr_i, pc_tag_i, ctx_i,
        output tpr_we_i, tpr_wctx_i, tpr_wdata_i, out_ready_i,
        input  in_ready_o, tpr_wready_o, out_valid_o,
        input  alu_mode_o, jump_pc_mode_o, class_o
    );

    modport slave (
        input  in_valid_i, instr_i, pc_tag_i, ctx_i,
        input  tpr_we_i, tpr_wctx_i, tpr_wdata_i, out_ready_i,
        output in_ready_o, tpr_wready_o, out_valid_o,
        output alu_mode_o, jump_pc_mode_o, class_o
    );
endinterface

// File: rtl/riscv_tag_mode_pipe_class_dec.sv
// Combinational RV32IM class decode. valid=0 means the tag passes through
// unchanged (MODE_OLD); unrecognised encodings report class 0.
module riscv_tag_class_dec
    import riscv_tag_pkg::*;
(
    input  logic [31:0] instr,
    output tag_class_e  cls,
    output logic        valid
);
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_bits;

    assign opcode      = instr[6:0];
    assign funct3      = instr[14:12];
    assign funct7      = instr[31:25];
    assign unused_bits = ^{instr[24:15], instr[11:7]};

    always_comb begin
        cls   = CLS_JUMP;
        valid = 1'b0;
        case (opcode)
            OPC_JAL:  valid = 1'b1;
            OPC_JALR: valid = (funct3 == 3'b000);
            OPC_BRANCH: begin
                cls   = CLS_BRANCH;
                valid = 1'b1;
            end
            OPC_STORE, OPC_LUI, OPC_AUIPC: begin
                cls   = CLS_LOADSTORE;
                valid = 1'b1;
            end
            // loads keep the memory tag, so the class is reported without a field
            OPC_LOAD: cls = CLS_LOADSTORE;
            OPC_OP: begin
                if (funct7 == F7_MULDIV) begin
                    cls   = CLS_INTEGER;
                    valid = 1'b1;
                end else if (funct7 == F7_BASE || funct7 == F7_ALT) begin
                    valid = 1'b1;
                    case (funct3)
                        3'b000:         cls = CLS_INTEGER;
                        3'b001, 3'b101: cls = CLS_SHIFT;
                        3'b010, 3'b011: cls = CLS_COMPARISON;
                        default:        cls = CLS_LOGICAL;
                    endcase
                    if (funct7 == F7_ALT && funct3 != 3'b000 && funct3 != 3'b101) begin
                        cls   = CLS_JUMP;
                        valid = 1'b0;
                    end
                end
            end
            OPC_OPIMM: begin
                valid = 1'b1;
                case (funct3)
                    3'b000:         cls = CLS_INTEGER;
                    3'b010, 3'b011: cls = CLS_COMPARISON;
                    3'b001: begin
                        cls   = CLS_SHIFT;
                        valid = (funct7 == F7_BASE);
                    end
                    3'b101: begin
                        cls   = CLS_SHIFT;
                        valid = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                    end
                    default:        cls = CLS_LOGICAL;
                endcase
                if (!valid) cls = CLS_JUMP;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/riscv_tag_mode_pipe.sv
// Tag-mode pipe: decodes each instruction against the active TPR context into a
// single output register; writes to an in-use context are deferred via DRAIN/COMMIT.
//
// state  | meaning
// RUN    | accept instructions and TPR writes
// DRAIN  | shadow write pending, waiting for the output register to empty
// COMMIT | shadow copied into the TPR array this cycle
module riscv_tag_mode_pipe
    import riscv_tag_pkg::*;
#(
    parameter int MODE_W  = 2,
    parameter int NUM_CTX = 2,
    parameter int TPR_W   = 8 * MODE_W
) (
    input logic                  clk,
    input logic                  rst,
    riscv_tag_mode_pipe_if.slave bus
);
    localparam int CTX_W = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1;
    localparam logic [MODE_W-1:0] OLD = MODE_W'(MODE_OLD);

    tag_state_e        state;
    tag_state_e        state_nxt;

    logic [TPR_W-1:0]  tpr [NUM_CTX];
    logic [TPR_W-1:0]  shadow_data;
    logic [CTX_W-1:0]  shadow_ctx;

    logic              out_valid;
    logic [MODE_W-1:0] alu_mode;
    logic [MODE_W-1:0] jpc_mode;
    tag_class_e        out_cls;
    logic [CTX_W-1:0]  out_ctx;

    tag_class_e        dec_cls;
    logic              dec_valid;
    logic [TPR_W-1:0]  tpr_rd;
    logic [MODE_W-1:0] dec_alu;
    logic [MODE_W-1:0] dec_jpc;

    logic              in_ready;
    logic              wready;
    logic              wr_hit;
    logic              wr_direct;
    logic              wr_shadow;
    logic              commit;
    logic              accept;
    logic              drain_done;

    riscv_tag_class_dec u_dec (
        .instr (bus.instr_i),
        .cls   (dec_cls),
        .valid (dec_valid)
    );

    assign tpr_rd = tpr[bus.ctx_i];

    always_comb begin
        dec_alu = OLD;
        dec_jpc = OLD;
        if (dec_valid && !(dec_cls == CLS_BRANCH && bus.pc_tag_i))
            dec_alu = tpr_rd[int'(dec_cls) * MODE_W +: MODE_W];
        if (dec_valid && dec_cls == CLS_JUMP)
            dec_jpc = tpr_rd[FLD_JUMP_PC * MODE_W +: MODE_W];
    end

    // a context is in use if a registered result came from it or it is being decoded now
    assign wr_hit     = (out_valid && bus.tpr_wctx_i == out_ctx) || (bus.tpr_wctx_i == bus.ctx_i);
    assign accept     = bus.in_valid_i && in_ready;
    assign drain_done = !out_valid || bus.out_ready_i;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_RUN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:    if (bus.tpr_we_i && wr_hit) state_nxt = ST_DRAIN;
            ST_DRAIN:  if (drain_done) state_nxt = ST_COMMIT;
            ST_COMMIT: state_nxt = ST_RUN;
            default:   state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        wready    = 1'b0;
        wr_direct = 1'b0;
        wr_shadow = 1'b0;
        commit    = 1'b0;
        if (!rst) begin
            case (state)
                ST_RUN: begin
                    in_ready  = !out_valid || bus.out_ready_i;
                    wready    = 1'b1;
                    wr_direct = bus.tpr_we_i && !wr_hit;
                    wr_shadow = bus.tpr_we_i && wr_hit;
                end
                ST_COMMIT: commit = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CTX; i++) tpr[i] <= '0;
            shadow_data <= '0;
            shadow_ctx  <= '0;
        end else begin
            if (wr_direct) tpr[bus.tpr_wctx_i] <= bus.tpr_wdata_i;
            if (commit)    tpr[shadow_ctx]     <= shadow_data;
            if (wr_shadow) begin
                shadow_data <= bus.tpr_wdata_i;
                shadow_ctx  <= bus.tpr_wctx_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            alu_mode  <= '0;
            jpc_mode  <= '0;
            out_cls   <= CLS_JUMP;
            out_ctx   <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            alu_mode  <= dec_alu;
            jpc_mode  <= dec_jpc;
            out_cls   <= dec_cls;
            out_ctx   <= bus.ctx_i;
        end else if (bus.out_ready_i) begin
            out_valid <= 1'b0;
        end
    end

    assign bus.in_ready_o     = in_ready;
    assign bus.tpr_wready_o   = wready;
    assign bus.out_valid_o    = out_valid;
    assign bus.alu_mode_o     = alu_mode;
    assign bus.jump_pc_mode_o = jpc_mode;
    assign bus.class_o        = out_cls;

endmodule

// File: tb/tb_riscv_tag_mode_pipe.sv
// Directed bench for riscv_tag_mode_pipe: a per-cycle reference model checks every
// output, and literal expectations pin the key scenarios.
module tb_riscv_tag_mode_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    riscv_tag_mode_pipe_if #(.MODE_W(2), .NUM_CTX(2), .TPR_W(16)) bus ();

    riscv_tag_mode_pipe #(.MODE_W(2), .NUM_CTX(2), .TPR_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int fld(input logic [15:0] t, input int k);
        return int'((t >> (2 * k)) & 16'h3);
    endfunction

    // reference decode written from the class rules: cls=-1 marks an unknown encoding
    function automatic void ref_decode(input logic [31:0] ins, input logic pct,
                                       input logic [15:0] t,
                                       output int alu, output int jpc, output int cls);
        int         oc;
        int         f3;
        int         f7;
        int         tab [8];
        tab = '{4, 5, 6, 6, 7, 5, 7, 7};
        oc  = int'(ins[6:0]);
        f3  = int'(ins[14:12]);
        f7  = int'(ins[31:25]);
        alu = 0;
        jpc = 0;
        cls = -1;
        if (oc == 'h6F || (oc == 'h67 && f3 == 0)) begin
            cls = 0;
            alu = fld(t, 0);
            jpc = fld(t, 1);
        end else if (oc == 'h63) begin
            cls = 2;
            alu = pct ? 0 : fld(t, 2);
        end else if (oc == 'h23 || oc == 'h37 || oc == 'h17) begin
            cls = 3;
            alu = fld(t, 3);
        end else if (oc == 'h03) begin
            cls = 3;
        end else if (oc == 'h33) begin
            if (f7 == 1) cls = 4;
            else if (f7 == 0) cls = tab[f3];
            else if (f7 == 'h20 && f3 == 0) cls = 4;
            else if (f7 == 'h20 && f3 == 5) cls = 5;
        end else if (oc == 'h13) begin
            if (f3 == 1) cls = (f7 == 0) ? 5 : -1;
            else if (f3 == 5) cls = (f7 == 0 || f7 == 'h20) ? 5 : -1;
            else cls = tab[f3];
        end
        if (cls < 0) begin
            cls = 0;
            alu = 0;
            jpc = 0;
        end else if (cls >= 2) begin
            if (oc != 'h63 && oc != 'h03) alu = fld(t, cls);
        end
    endfunction

    logic [15:0] m_tpr [2];
    int          exp_valid = 0;
    int          exp_alu   = 0;
    int          exp_jpc   = 0;
    int          exp_cls   = 0;
    bit          armed     = 0;

    always @(negedge clk) begin
        int a, j, c;
        if (armed) begin
            chk("mon_out_valid", bus.out_valid_o, exp_valid);
            chk("mon_alu_mode", bus.alu_mode_o, exp_alu);
            chk("mon_jump_pc_mode", bus.jump_pc_mode_o, exp_jpc);
            chk("mon_class", bus.class_o, exp_cls);
            if (bus.out_valid_o && !bus.out_ready_i) chk("mon_bp_in_ready", bus.in_ready_o, 0);
        end
        if (rst) begin
            chk("mon_rst_in_ready", bus.in_ready_o, 0);
            chk("mon_rst_wready", bus.tpr_wready_o, 0);
            m_tpr[0]  = '0;
            m_tpr[1]  = '0;
            exp_valid = 0;
            exp_alu   = 0;
            exp_jpc   = 0;
            exp_cls   = 0;
            armed     = 1;
        end else begin
            if (bus.in_valid_i && bus.in_ready_o) begin
                ref_decode(bus.instr_i, bus.pc_tag_i, m_tpr[bus.ctx_i], a, j, c);
                exp_valid = 1;
                exp_alu   = a;
                exp_jpc   = j;
                exp_cls   = c;
            end else if (bus.out_ready_i) begin
                exp_valid = 0;
            end
            if (bus.tpr_we_i && bus.tpr_wready_o) m_tpr[bus.tpr_wctx_i] = bus.tpr_wdata_i;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] ins, input logic pct, input logic c);
        int n;
        bus.in_valid_i = 1'b1;
        bus.instr_i    = ins;
        bus.pc_tag_i   = pct;
        bus.ctx_i      = c;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready_o) chk("send_timeout", bus.in_ready_o, 1);
        tick();
        bus.in_valid_i = 1'b0;
    endtask

    task automatic write_tpr(input logic wc, input logic [15:0] d);
        int n;
        bus.tpr_we_i    = 1'b1;
        bus.tpr_wctx_i  = wc;
        bus.tpr_wdata_i = d;
        n = 0;
        @(negedge clk);
        while (!bus.tpr_wready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.tpr_wready_o) chk("write_timeout", bus.tpr_wready_o, 1);
        tick();
        bus.tpr_we_i = 1'b0;
    endtask

    typedef struct {
        logic [31:0] ins;
        logic        pct;
        logic        c;
    } vec_t;

    localparam logic [31:0] I_ADD = 32'h003100B3;
    localparam logic [31:0] I_JAL = 32'h000000EF;
    localparam logic [31:0] I_BEQ = 32'h00000063;
    localparam logic [31:0] I_SLL = 32'h003110B3;
    localparam logic [31:0] I_XOR = 32'h003140B3;

    vec_t vecs [28];

    initial begin
        vecs = '{
            '{32'h003100B3, 1'b0, 1'b0}, '{32'h403100B3, 1'b0, 1'b0}, '{32'h003110B3, 1'b0, 1'b0},
            '{32'h003120B3, 1'b0, 1'b0}, '{32'h003130B3, 1'b0, 1'b0}, '{32'h003140B3, 1'b0, 1'b0},
            '{32'h003160B3, 1'b0, 1'b0}, '{32'h003170B3, 1'b0, 1'b0}, '{32'h023100B3, 1'b0, 1'b0},
            '{32'h023140B3, 1'b0, 1'b1}, '{32'h403110B3, 1'b0, 1'b0}, '{32'h083100B3, 1'b0, 1'b0},
            '{32'h00510093, 1'b0, 1'b0}, '{32'h00512093, 1'b0, 1'b1}, '{32'h00514093, 1'b0, 1'b0},
            '{32'h00516093, 1'b0, 1'b0}, '{32'h00111093, 1'b0, 1'b0}, '{32'h40115093, 1'b0, 1'b0},
            '{32'h40111093, 1'b0, 1'b0}, '{32'h000000EF, 1'b1, 1'b0}, '{32'h000100E7, 1'b0, 1'b1},
            '{32'h00000063, 1'b0, 1'b0}, '{32'h00000063, 1'b1, 1'b0}, '{32'h00012083, 1'b0, 1'b0},
            '{32'h00312023, 1'b0, 1'b0}, '{32'h000000B7, 1'b0, 1'b1}, '{32'h00000097, 1'b0, 1'b0},
            '{32'h0000007F, 1'b0, 1'b0}
        };
        bus.in_valid_i  = 1'b0;
        bus.instr_i     = '0;
        bus.pc_tag_i    = 1'b0;
        bus.ctx_i       = 1'b0;
        bus.tpr_we_i    = 1'b0;
        bus.tpr_wctx_i  = 1'b0;
        bus.tpr_wdata_i = '0;
        bus.out_ready_i = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_in_ready", bus.in_ready_o, 0);
        chk("rst_wready", bus.tpr_wready_o, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", bus.out_valid_o, 0);
        chk("post_rst_alu", bus.alu_mode_o, 0);
        chk("post_rst_in_ready", bus.in_ready_o, 1);
        tick();

        // TPR0 fields J=1 JPC=2 BR=3 LS=1 INT=3 SH=2 CMP=1 LOG=2; TPR1 all 01
        bus.ctx_i = 1'b1;
        write_tpr(1'b0, 16'h9B79);
        bus.ctx_i = 1'b0;
        write_tpr(1'b1, 16'h5555);

        send(I_ADD, 1'b0, 1'b0);
        @(negedge clk);
        chk("add_valid", bus.out_valid_o, 1);
        chk("add_alu", bus.alu_mode_o, 3);
        chk("add_jpc", bus.jump_pc_mode_o, 0);
        chk("add_class", bus.class_o, 4);
        tick();
        send(I_JAL, 1'b0, 1'b0);
        @(negedge clk);
        chk("jal_alu", bus.alu_mode_o, 1);
        chk("jal_jpc", bus.jump_pc_mode_o, 2);
        tick();
        send(I_BEQ, 1'b1, 1'b0);
        @(negedge clk);
        chk("beq_tag_alu", bus.alu_mode_o, 0);
        chk("beq_tag_class", bus.class_o, 2);
        tick();
        send(I_BEQ, 1'b0, 1'b0);
        @(negedge clk);
        chk("beq_notag_alu", bus.alu_mode_o, 3);
        tick();

        foreach (vecs[i]) begin
            bus.in_valid_i = 1'b1;
            bus.instr_i    = vecs[i].ins;
            bus.pc_tag_i   = vecs[i].pct;
            bus.ctx_i      = vecs[i].c;
            @(negedge clk);
            chk("stream_in_ready", bus.in_ready_o, 1);
            tick();
        end
        bus.in_valid_i = 1'b0;
        bus.ctx_i      = 1'b0;
        tick();

        // backpressure: second instruction waits, first held stable
        bus.out_ready_i = 1'b0;
        send(I_SLL, 1'b0, 1'b0);
        bus.in_valid_i = 1'b1;
        bus.instr_i    = I_XOR;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", bus.in_ready_o, 0);
            chk("bp_hold_alu", bus.alu_mode_o, 2);
            chk("bp_hold_class", bus.class_o, 5);
            tick();
        end
        bus.out_ready_i = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", bus.in_ready_o, 1);
        tick();
        bus.in_valid_i = 1'b0;
        @(negedge clk);
        chk("bp_second_valid", bus.out_valid_o, 1);
        chk("bp_second_class", bus.class_o, 7);
        tick();
        @(negedge clk);
        chk("bp_no_dup", bus.out_valid_o, 0);
        tick();

        // write to the in-use context: DRAIN, a held-off write, then COMMIT
        bus.out_ready_i = 1'b0;
        send(I_ADD, 1'b0, 1'b0);
        bus.tpr_we_i    = 1'b1;
        bus.tpr_wctx_i  = 1'b0;
        bus.tpr_wdata_i = 16'h9979;
        @(negedge clk);
        chk("drain_wready_run", bus.tpr_wready_o, 1);
        tick();
        bus.tpr_wctx_i  = 1'b1;
        bus.tpr_wdata_i = 16'hFFFF;
        @(negedge clk);
        chk("drain_in_ready", bus.in_ready_o, 0);
        chk("drain_wready", bus.tpr_wready_o, 0);
        chk("drain_old_alu", bus.alu_mode_o, 3);
        tick();
        bus.out_ready_i = 1'b1;
        @(negedge clk);
        chk("drain_done_in_ready", bus.in_ready_o, 0);
        tick();
        @(negedge clk);
        chk("commit_in_ready", bus.in_ready_o, 0);
        chk("commit_wready", bus.tpr_wready_o, 0);
        chk("commit_valid", bus.out_valid_o, 0);
        tick();
        @(negedge clk);
        chk("run_in_ready", bus.in_ready_o, 1);
        chk("run_held_write", bus.tpr_wready_o, 1);
        tick();
        bus.tpr_we_i = 1'b0;
        send(I_ADD, 1'b0, 1'b0);
        @(negedge clk);
        chk("commit_new_alu", bus.alu_mode_o, 1);
        tick();
        send(I_ADD, 1'b0, 1'b1);
        @(negedge clk);
        chk("held_write_ctx1_alu", bus.alu_mode_o, 3);
        tick();

        // write to the other context alongside an instruction: no stall
        bus.in_valid_i  = 1'b1;
        bus.instr_i     = I_ADD;
        bus.ctx_i       = 1'b0;
        bus.tpr_we_i    = 1'b1;
        bus.tpr_wctx_i  = 1'b1;
        bus.tpr_wdata_i = 16'h0200;
        @(negedge clk);
        chk("other_in_ready", bus.in_ready_o, 1);
        chk("other_wready", bus.tpr_wready_o, 1);
        tick();
        bus.in_valid_i = 1'b0;
        bus.tpr_we_i   = 1'b0;
        @(negedge clk);
        chk("other_ctx0_alu", bus.alu_mode_o, 1);
        chk("other_no_stall", bus.in_ready_o, 1);
        tick();
        send(I_ADD, 1'b0, 1'b1);
        @(negedge clk);
        chk("other_ctx1_alu", bus.alu_mode_o, 2);
        tick();

        // same-context write with an instruction: instruction sees the old value
        bus.in_valid_i  = 1'b1;
        bus.instr_i     = I_ADD;
        bus.ctx_i       = 1'b0;
        bus.tpr_we_i    = 1'b1;
        bus.tpr_wctx_i  = 1'b0;
        bus.tpr_wdata_i = 16'h9B79;
        @(negedge clk);
        chk("same_in_ready", bus.in_ready_o, 1);
        chk("same_wready", bus.tpr_wready_o, 1);
        tick();
        bus.in_valid_i = 1'b0;
        bus.tpr_we_i   = 1'b0;
        @(negedge clk);
        chk("same_old_alu", bus.alu_mode_o, 1);
        tick();
        send(I_ADD, 1'b0, 1'b0);
        @(negedge clk);
        chk("same_new_alu", bus.alu_mode_o, 3);
        tick();

        // reset while draining discards the shadow and the pending result
        bus.out_ready_i = 1'b0;
        send(I_ADD, 1'b0, 1'b0);
        write_tpr(1'b0, 16'hFFFF);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_drain_in_ready", bus.in_ready_o, 0);
        chk("rst_drain_wready", bus.tpr_wready_o, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_drain_valid", bus.out_valid_o, 0);
        chk("rst_drain_run", bus.in_ready_o, 1);
        tick();
        bus.out_ready_i = 1'b1;
        send(I_ADD, 1'b0, 1'b0);
        @(negedge clk);
        chk("rst_add_alu", bus.alu_mode_o, 0);
        tick();
        send(I_JAL, 1'b0, 1'b0);
        @(negedge clk);
        chk("rst_jal_alu", bus.alu_mode_o, 0);
        chk("rst_jal_jpc", bus.jump_pc_mode_o, 0);
        tick();

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
